// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Integer register file for the pipelined core, with a built-in scoreboard.
// The scoreboard holds one busy bit per register. Issue marks the destination
// busy, writeback clears it, and flush clears every bit. Reads are
// combinational, and a same-cycle writeback can optionally be forwarded to
// the read ports. Operand values and hazard flags go to the issue stage.
//
// Parameters:
//   XLEN     - data width of each register
//   NREGS    - number of architectural registers (power of two, 2..64)
//   AW       - register address width, derived from NREGS
//   NRD      - number of read ports (1..4)
//   ZERO_REG - 1: register 0 reads zero, ignores writes, never busy
//   BYPASS   - 1: same-cycle write forwards to matching read ports
//
// Ports:
//   Clock       - system clock, rising edge
//   nReset      - asynchronous active-low reset
//   we          - writeback enable
//   waddr       - writeback destination
//   wdata       - writeback data
//   raddr       - packed read addresses, port i = [i*AW +: AW]
//   rdata       - packed read data, port i = [i*XLEN +: XLEN]
//   rbusy       - per-port flag: operand still has an outstanding producer
//   issue_valid - an instruction issued this cycle
//   issue_rd    - destination register of the issued instruction
//   flush       - pipeline flush, clears all busy bits
//   busy_vec    - registered busy bits (debug/perf, no bypass applied)
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    localparam int AW       = $clog2(NREGS),
    parameter int  NRD      = 2,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic [AW-1:0]    rAddr  [NRD];
    logic [NRD-1:0]   isZero;
    logic [NRD-1:0]   fwd;
    logic             wrZero;
    logic             wrEn;

    // Writes to the hardwired zero register are dropped entirely.
    assign wrZero = ZERO_REG && (waddr == '0);
    assign wrEn   = we && !wrZero;

    // Per-port address decode. A port forwards when it is reading the
    // register that is being written this cycle. The zero register never
    // forwards, because wrEn is already low for it.
    for (genvar g = 0; g < NRD; g++) begin : gPortDecode
        assign rAddr[g]  = raddr[g*AW +: AW];
        assign isZero[g] = ZERO_REG && (rAddr[g] == '0);
        assign fwd[g]    = BYPASS && wrEn && (waddr == rAddr[g]);
    end

    // Next register contents: only the single writeback port can modify
    // the array.
    always_comb begin
        regs_d = regs_q;
        if (wrEn) begin
            regs_d[waddr] = wdata;
        end
    end

    // Scoreboard next state. Flush wins over everything and discards a
    // same-cycle issue. Otherwise the clear from writeback is applied first
    // and the set from issue second. When both target the same register,
    // the new producer keeps the register busy. Bit 0 is forced low when
    // register 0 is hardwired.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (we) begin
                busy_d[waddr] = 1'b0;
            end
            if (issue_valid) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // State registers. Reset clears them asynchronously, independent of
    // the clock.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports. Outputs are held at zero while reset is
    // asserted, so a forwarded wdata cannot leak out during reset. A port
    // that forwards reports not-busy, because its operand arrives this cycle.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (nReset && !isZero[i]) begin
                if (fwd[i]) begin
                    rdata[i*XLEN +: XLEN] = wdata;
                end else begin
                    rdata[i*XLEN +: XLEN] = regs_q[rAddr[i]];
                end
                rbusy[i] = !fwd[i] && busy_q[rAddr[i]];
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed testbench for reg_file_sb. Two instances share every input: one
// with forwarding enabled and one with it disabled. Expected values are
// worked out by hand for each step. Inputs change on the falling clock edge,
// and outputs are sampled 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                Clock;
    logic                nReset;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                flush;

    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NREGS-1:0]    busy_vec;
    logic [NRD*XLEN-1:0] rdataNb;
    logic [NRD-1:0]      rbusyNb;
    logic [NREGS-1:0]    busyVecNb;

    int checkCount = 0;
    int errorCount = 0;

    reg_file_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .Clock(Clock), .nReset(nReset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec)
    );

    reg_file_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dutNb (
        .Clock(Clock), .nReset(nReset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdataNb), .rbusy(rbusyNb), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .flush(flush), .busy_vec(busyVecNb)
    );

    // Free-running clock with a 10-unit period.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drive every input in one step. Read port 1 goes in the upper address bits.
    task automatic applyStimulus(input logic weV, input logic [AW-1:0] waV,
                                 input logic [XLEN-1:0] wdV, input logic [AW-1:0] ra0,
                                 input logic [AW-1:0] ra1, input logic ivV,
                                 input logic [AW-1:0] irV, input logic flV);
        we          = weV;
        waddr       = waV;
        wdata       = wdV;
        raddr       = {ra1, ra0};
        issue_valid = ivV;
        issue_rd    = irV;
        flush       = flV;
    endtask

    // One comparison: count it, and report and count a failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Run one rising edge, then return to the falling edge for new stimulus.
    task automatic stepClock();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        // Reset held with random activity on every input.
        nReset = 1'b0;
        applyStimulus(1'b1, AW'($urandom_range(1, 31)), $urandom,
                      AW'($urandom_range(1, 31)), AW'($urandom_range(1, 31)),
                      1'b1, AW'($urandom_range(1, 31)), 1'b0);
        @(negedge Clock);
        stepClock();
        #1;
        checkOutput("rstHeldRdata", 64'(rdata), 64'h0);
        checkOutput("rstHeldRbusy", 64'(rbusy), 64'h0);
        checkOutput("rstHeldBusyVec", 64'(busy_vec), 64'h0);
        checkOutput("rstHeldRdataNb", 64'(rdataNb), 64'h0);

        // Release reset with idle inputs.
        @(negedge Clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd17, 1'b0, 5'd0, 1'b0);
        nReset = 1'b1;
        stepClock();
        #1;
        checkOutput("rstRelRdata", 64'(rdata), 64'h0);
        checkOutput("rstRelRbusy", 64'(rbusy), 64'h0);
        checkOutput("rstRelBusyVec", 64'(busy_vec), 64'h0);

        // Write register 5 and read it in the same cycle.
        @(negedge Clock);
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("bypassRdata0", 64'(rdata[31:0]), 64'hDEADBEEF);
        checkOutput("noBypassRdata0", 64'(rdataNb[31:0]), 64'h0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("afterWrRdata0", 64'(rdata[31:0]), 64'hDEADBEEF);
        checkOutput("noBypassNextRdata0", 64'(rdataNb[31:0]), 64'hDEADBEEF);
        checkOutput("wrNonBusyBusyVec", 64'(busy_vec), 64'h0);

        // Write and issue to register 0: both are ignored.
        @(negedge Clock);
        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        checkOutput("zeroRegBypass", 64'(rdata), 64'h0);
        checkOutput("zeroRegRbusy", 64'(rbusy), 64'h0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("zeroRegRead", 64'(rdata[31:0]), 64'h0);
        checkOutput("zeroRegBusyVec", 64'(busy_vec), 64'h0);

        // Issue to register 7, then read it while it is busy.
        @(negedge Clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0);
        #1;
        checkOutput("issueSameCycleRbusy", 64'(rbusy), 64'h0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("busy7Rbusy", 64'(rbusy), 64'h2);
        checkOutput("busy7BusyVec", 64'(busy_vec), 64'h80);

        // Writeback to register 7 in the same cycle.
        @(negedge Clock);
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("wb7Rbusy", 64'(rbusy), 64'h0);
        checkOutput("wb7Rdata1", 64'(rdata[63:32]), 64'hA5A5A5A5);
        checkOutput("wb7RbusyNb", 64'(rbusyNb), 64'h2);
        checkOutput("wb7Rdata1Nb", 64'(rdataNb[63:32]), 64'h0);
        checkOutput("wb7BusyVecStill", 64'(busy_vec), 64'h80);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("wb7BusyVecClr", 64'(busy_vec), 64'h0);
        checkOutput("wb7Rdata1Next", 64'(rdata[63:32]), 64'hA5A5A5A5);

        // Issue and writeback to register 9 in the same cycle: the new
        // producer wins.
        @(negedge Clock);
        applyStimulus(1'b1, 5'd9, 32'h13579BDF, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("iw9BusyVec", 64'(busy_vec), 64'h200);
        checkOutput("iw9Rdata0", 64'(rdata[31:0]), 64'h13579BDF);
        checkOutput("iw9Rbusy", 64'(rbusy), 64'h1);

        // Set registers 3, 4 and 8 busy, and re-issue 8 to confirm it stays busy.
        @(negedge Clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd8, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("multiBusyVec", 64'(busy_vec), 64'h318);
        checkOutput("multiRbusy", 64'(rbusy), 64'h3);

        // Flush with a same-cycle issue to 10 and a write to 12: the issue is
        // dropped, but the write still lands.
        @(negedge Clock);
        applyStimulus(1'b1, 5'd12, 32'hCAFEF00D, 5'd0, 5'd0, 1'b1, 5'd10, 1'b1);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd9, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("flushBusyVec", 64'(busy_vec), 64'h0);
        checkOutput("flushWrite12", 64'(rdata[31:0]), 64'hCAFEF00D);
        checkOutput("flushRdata9", 64'(rdata[63:32]), 64'h13579BDF);

        // Mark register 6 busy, then assert reset mid-write between clock edges.
        @(negedge Clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        stepClock();
        applyStimulus(1'b1, 5'd5, 32'h11111111, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("preRstRbusy", 64'(rbusy), 64'h2);
        #1;
        nReset = 1'b0;
        #1;
        checkOutput("midRstRdata", 64'(rdata), 64'h0);
        checkOutput("midRstRbusy", 64'(rbusy), 64'h0);
        checkOutput("midRstBusyVec", 64'(busy_vec), 64'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd9, 1'b0, 5'd0, 1'b0);
        #1;
        nReset = 1'b1;
        #1;
        checkOutput("postRstRdata", 64'(rdata), 64'h0);
        checkOutput("postRstBusyVecNb", 64'(busyVecNb), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the pipelined core.
- Configurable data width, register count and number of read ports.
- x0 hardwired to zero; optional write-to-read bypass.
- Integrated scoreboard with one busy bit per register: issue marks the destination busy, writeback clears it, flush clears all.
- Sits between decode/issue and writeback; drives operand values and hazard flags to the issue stage.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- AW, $clog2(NREGS), register address width (derived, not overridden).
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes and is never busy.
- BYPASS, 1, 1 = a same-cycle write forwards to matching read ports.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- we  in  1  writeback enable.
- waddr  in  AW  writeback destination.
- wdata  in  XLEN  writeback data.
- raddr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- rbusy  out  NRD  port i operand has an outstanding producer.
- issue_valid  in  1  instruction issued this cycle, marks issue_rd busy.
- issue_rd  in  AW  destination of the issued instruction.
- flush  in  1  pipeline flush, clears every busy bit.
- busy_vec  out  NREGS  current registered busy bits, for debug/perf.

Behaviour:
- Reset (nReset low, asynchronous): all registers = 0; all busy bits = 0.
  - Consequently busy_vec = 0 and rbusy = 0 while reset is held.
  - rdata = 0 for every port while reset is held.
- Write: at the rising edge, if we=1 the register at waddr <= wdata.
  - With ZERO_REG=1 and waddr=0 the write is dropped.
- Read: combinational, zero latency. rdata[i] = reg[raddr[i]].
  - ZERO_REG=1 and raddr[i]=0 -> rdata[i]=0 regardless of stored or bypassed value.
- Bypass (BYPASS=1): if we=1, waddr=raddr[i] and the address is not the zero register, rdata[i]=wdata in the same cycle.
  - BYPASS=0: the new value is visible from the cycle after the edge.
- Busy bit update at each rising edge, in priority order:
  1. flush=1: all busy <= 0, and a same-cycle issue is discarded. The register write still occurs.
  2. issue_valid=1 and issue_rd == waddr with we=1: busy[issue_rd] <= 1. The new producer wins over the retiring one.
  3. Otherwise: busy[issue_rd] <= 1 if issue_valid; busy[waddr] <= 0 if we.
  - issue_rd=0 with ZERO_REG=1 never sets a busy bit; busy[0] is always 0.
  - A write to a non-busy register is legal and leaves its busy bit 0.
  - Re-issuing to an already-busy register keeps it busy (single bit, no counting).
- rbusy[i] = busy[raddr[i]].
  - With BYPASS=1, rbusy[i] is forced to 0 when the write to that address in the current cycle forwards (same conditions as the data bypass).
  - rbusy[i] = 0 for the zero register.
  - rbusy is combinational and does not see same-cycle issue_valid.
- busy_vec = registered busy bits; no bypass applied.
- Read ports are fully independent: any number may address the same register.
- Reset mid-operation: registers and busy bits clear immediately, with no dependence on Clock.

Test Plan:
- Reset with random stimulus, then release -> every rdata = 0, busy_vec = 0, rbusy = 0.
- we=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 in the same cycle -> rdata0 = 0xDEADBEEF combinationally (BYPASS=1); with BYPASS=0 the old value 0 is read that cycle and 0xDEADBEEF the next.
- Write 0x12345678 to register 0 -> reading register 0 returns 0; issue_rd=0 leaves busy_vec[0]=0.
- Issue to register 7, then raddr1=7 -> rbusy1=1 and busy_vec[7]=1.
  - Writeback to 7 with 0xA5A5A5A5 that cycle -> rbusy1=0 and rdata1=0xA5A5A5A5.
  - Next cycle -> busy_vec[7]=0.
- Issue to register 9 and writeback to register 9 in the same cycle -> busy_vec[9]=1 after the edge, reg[9] updated.
- Busy bits set on registers 3, 4 and 8, then flush=1 together with issue_valid to register 10 -> busy_vec = 0 after the edge. Then assert nReset low mid-write -> all registers immediately read 0.
